// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - sync, debounce and edge-detect two active-low keys into gated one-cycle pulses
// Optional auto-repeat while a key is held: define HOLD_REPEAT_EN.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 12500000
) (
    input  logic clock,
    input  logic resetN,
    input  logic incButRaw,
    input  logic decButRaw,
    input  logic enable,
    output logic incPulse,
    output logic decPulse,
    output logic incLevel,
    output logic decLevel
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("button_conditioner: illegal parameter value");
    end

    // Index 0 = increment key, index 1 = decrement key.
    logic [1:0] sync_meta;
    logic [1:0] sync_out;
    logic [1:0] pressed_sync;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sync_meta <= 2'b11;
            sync_out  <= 2'b11;
        end else begin
            sync_meta <= {decButRaw, incButRaw};
            sync_out  <= sync_meta;
        end
    end

    assign pressed_sync = ~sync_out;

    state_t        state_q [2];
    state_t        state_d [2];
    logic [CW-1:0] cnt_q   [2];
    logic [CW-1:0] cnt_d   [2];
    logic [1:0]    press_done;
    logic [1:0]    level_d;
    logic [1:0]    raw_evt;

    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        press_done = '0;
        level_d    = '0;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (pressed_sync[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_sync[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]    = HELD;
                        cnt_d[i]      = '0;
                        press_done[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_inc(cnt_q[i]);
                    end
                end
                HELD: begin
                    if (!pressed_sync[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed_sync[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_inc(cnt_q[i]);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            level_d[i] = (state_d[i] == HELD) || (state_d[i] == RELEASE_WAIT);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

`ifdef HOLD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(RMAX + 1);
    // The edge that enters HELD already counts as one held cycle, hence -2 for the first repeat.
    localparam logic [TW-1:0] FIRST_LAST  = TW'(REPEAT_DELAY - 2);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
    localparam logic [TW-1:0] TMR_ONE     = TW'(1);

    logic [TW-1:0] timer_q [2];
    logic [1:0]    first_q;
    logic [1:0]    rep_evt;

    always_comb begin
        rep_evt = '0;
        for (int i = 0; i < 2; i++) begin
            rep_evt[i] = (state_q[i] == HELD) && pressed_sync[i] &&
                         (timer_q[i] == (first_q[i] ? FIRST_LAST : PERIOD_LAST));
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < 2; i++) begin
                timer_q[i] <= '0;
            end
            first_q <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (state_q[i] != HELD || !pressed_sync[i]) begin
                    timer_q[i] <= '0;
                    first_q[i] <= 1'b1;
                end else if (rep_evt[i]) begin
                    timer_q[i] <= '0;
                    first_q[i] <= 1'b0;
                end else begin
                    timer_q[i] <= timer_q[i] + TMR_ONE;
                end
            end
        end
    end

    assign raw_evt = press_done | rep_evt;
`else
    assign raw_evt = press_done;
`endif

    // Coincident inc/dec events cancel each other; gated events are dropped, not queued.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            incPulse <= 1'b0;
            decPulse <= 1'b0;
            incLevel <= 1'b0;
            decLevel <= 1'b0;
        end else begin
            incPulse <= enable & raw_evt[0] & ~raw_evt[1];
            decPulse <= enable & raw_evt[1] & ~raw_evt[0];
            incLevel <= level_d[0];
            decLevel <= level_d[1];
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4)
module tb_button_conditioner;

    logic clock;
    logic resetN;
    logic incButRaw;
    logic decButRaw;
    logic enable;
    logic incPulse;
    logic decPulse;
    logic incLevel;
    logic decLevel;

    int vectors;
    int miscompares;

    logic [3:0] outs;
    logic [3:0] exp_v;
    assign outs = {incPulse, decPulse, incLevel, decLevel};

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clock    (clock),
        .resetN   (resetN),
        .incButRaw(incButRaw),
        .decButRaw(decButRaw),
        .enable   (enable),
        .incPulse (incPulse),
        .decPulse (decPulse),
        .incLevel (incLevel),
        .decLevel (decLevel)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset;
        resetN    = 1'b0;
        incButRaw = 1'b1;
        decButRaw = 1'b1;
        enable    = 1'b1;
        repeat (3) step();
        vectors++;
        if (outs !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_assert: got %b want 0000", outs);
        end
        resetN = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            step();
            vectors++;
            if (outs !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_idle c=%0d: got %b want 0000", c, outs);
            end
        end
    endtask

    // First edge after driving the key is c=1; acceptance lands at c = DEBOUNCE_CYCLES + 2.
    task automatic test_inc_press;
        incButRaw = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_v = {c == 6, 1'b0, c >= 6, 1'b0};
            vectors++;
            if (outs !== exp_v) begin
                miscompares++;
                $display("FAIL inc_press c=%0d: got %b want %b", c, outs, exp_v);
            end
        end
        incButRaw = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_v = {2'b00, c < 6, 1'b0};
            vectors++;
            if (outs !== exp_v) begin
                miscompares++;
                $display("FAIL inc_release c=%0d: got %b want %b", c, outs, exp_v);
            end
        end
    endtask

    task automatic test_dec_bounce;
        for (int r = 0; r < 5; r++) begin
            for (int p = 0; p < 3; p++) begin
                decButRaw = (p == 2);
                step();
                vectors++;
                if (outs !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL dec_bounce r=%0d p=%0d: got %b want 0000", r, p, outs);
                end
            end
        end
        decButRaw = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_v = {1'b0, c == 6, 1'b0, c >= 6};
            vectors++;
            if (outs !== exp_v) begin
                miscompares++;
                $display("FAIL dec_settle c=%0d: got %b want %b", c, outs, exp_v);
            end
        end
        for (int c = 1; c <= 10; c++) begin
            decButRaw = !(c <= 2);
            decButRaw = (c <= 2);
            step();
            vectors++;
            if (outs !== 4'b0001) begin
                miscompares++;
                $display("FAIL dec_glitch c=%0d: got %b want 0001", c, outs);
            end
        end
        decButRaw = 1'b0;
        decButRaw = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_v = {3'b000, c < 6};
            vectors++;
            if (outs !== exp_v) begin
                miscompares++;
                $display("FAIL dec_release c=%0d: got %b want %b", c, outs, exp_v);
            end
        end
    endtask

    task automatic test_enable_gate;
        enable    = 1'b0;
        incButRaw = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_v = {2'b00, c >= 6, 1'b0};
            vectors++;
            if (outs !== exp_v) begin
                miscompares++;
                $display("FAIL gate_press c=%0d: got %b want %b", c, outs, exp_v);
            end
        end
        incButRaw = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_v = {2'b00, c < 6, 1'b0};
            vectors++;
            if (outs !== exp_v) begin
                miscompares++;
                $display("FAIL gate_release c=%0d: got %b want %b", c, outs, exp_v);
            end
        end
        enable = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            vectors++;
            if (outs !== 4'b0000) begin
                miscompares++;
                $display("FAIL gate_no_replay c=%0d: got %b want 0000", c, outs);
            end
        end
    endtask

    task automatic test_simultaneous;
        incButRaw = 1'b0;
        decButRaw = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_v = {2'b00, c >= 6, c >= 6};
            vectors++;
            if (outs !== exp_v) begin
                miscompares++;
                $display("FAIL simul_press c=%0d: got %b want %b", c, outs, exp_v);
            end
        end
        incButRaw = 1'b1;
        decButRaw = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_v = {2'b00, c < 6, c < 6};
            vectors++;
            if (outs !== exp_v) begin
                miscompares++;
                $display("FAIL simul_release c=%0d: got %b want %b", c, outs, exp_v);
            end
        end
        incButRaw = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_v = {c == 6, 1'b0, c >= 6, 1'b0};
            vectors++;
            if (outs !== exp_v) begin
                miscompares++;
                $display("FAIL simul_inc_alone c=%0d: got %b want %b", c, outs, exp_v);
            end
        end
        incButRaw = 1'b1;
        repeat (10) step();
    endtask

    task automatic test_reset_mid_hold;
        incButRaw = 1'b0;
        repeat (8) step();
        vectors++;
        if (outs !== 4'b0010) begin
            miscompares++;
            $display("FAIL midreset_before: got %b want 0010", outs);
        end
        resetN = 1'b0;
        #1;
        vectors++;
        if (outs !== 4'b0000) begin
            miscompares++;
            $display("FAIL midreset_immediate: got %b want 0000", outs);
        end
        step();
        resetN = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_v = {c == 6, 1'b0, c >= 6, 1'b0};
            vectors++;
            if (outs !== exp_v) begin
                miscompares++;
                $display("FAIL midreset_redebounce c=%0d: got %b want %b", c, outs, exp_v);
            end
        end
        incButRaw = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_v = {2'b00, c < 6, 1'b0};
            vectors++;
            if (outs !== exp_v) begin
                miscompares++;
                $display("FAIL midreset_release c=%0d: got %b want %b", c, outs, exp_v);
            end
        end
    endtask

`ifdef HOLD_REPEAT_EN
    // Relative cycle r = c - 5 so the press pulse is r=1; repeats expected at 20, 28, 36, 44, 52.
    task automatic test_hold_repeat;
        int r;
        logic want_pulse;
        incButRaw = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            step();
            r = c - 5;
            want_pulse = (r == 1) || (r == 20) || (r == 28) || (r == 36) || (r == 44) || (r == 52);
            exp_v = {want_pulse, 1'b0, c >= 6, 1'b0};
            vectors++;
            if (outs !== exp_v) begin
                miscompares++;
                $display("FAIL hold_repeat r=%0d: got %b want %b", r, outs, exp_v);
            end
        end
        resetN = 1'b0;
        #1;
        vectors++;
        if (outs !== 4'b0000) begin
            miscompares++;
            $display("FAIL repeat_reset_immediate: got %b want 0000", outs);
        end
        incButRaw = 1'b1;
        step();
        resetN = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            vectors++;
            if (outs !== 4'b0000) begin
                miscompares++;
                $display("FAIL repeat_after_reset c=%0d: got %b want 0000", c, outs);
            end
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetN      = 1'b0;
        incButRaw   = 1'b1;
        decButRaw   = 1'b1;
        enable      = 1'b1;
        test_reset();
        test_inc_press();
        test_dec_bounce();
        test_enable_gate();
        test_simultaneous();
        test_reset_mid_hold();
`ifdef HOLD_REPEAT_EN
        test_hold_repeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage for the student counter. It takes the two raw, active-low push-button inputs (increment, decrement) and produces clean one-cycle event pulses for the counter core.
- Per button, it synchronizes, debounces and edge-detects the input. It also gates events with the on/off enable and drops simultaneous increment/decrement events.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples needed to accept a press or release (10 ms at 50 MHz); legal range ≥2.
- REPEAT_DELAY, 25000000, hold time in cycles before the first auto-repeat pulse (used only with HOLD_REPEAT_EN).
- REPEAT_PERIOD, 12500000, cycles between auto-repeat pulses (used only with HOLD_REPEAT_EN).

Ports:
- clock  input  1  system clock, 50 MHz.
- resetN  input  1  asynchronous, active-low reset.
- incButRaw  input  1  raw increment key, 0 = pressed, asynchronous to clock.
- decButRaw  input  1  raw decrement key, 0 = pressed, asynchronous to clock.
- enable  input  1  on/off switch level; 0 blocks all pulses.
- incPulse  output  1  one-cycle increment event.
- decPulse  output  1  one-cycle decrement event.
- incLevel  output  1  debounced pressed state of the increment key (1 = pressed).
- decLevel  output  1  debounced pressed state of the decrement key (1 = pressed).

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low, on resetN, and is the only reset.
- Reset values:
  - synchronizer flops = 1 (released);
  - FSMs = IDLE;
  - debounce counters = 0;
  - incPulse = decPulse = incLevel = decLevel = 0.
- Synchronizer: each raw input passes through a 2-flop synchronizer and is then inverted to give pressedSync (1 = pressed). No logic sits between the two flops.
- Per-button FSM (identical instances): states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Counter width is $clog2(DEBOUNCE_CYCLES+1); the counter saturates and never wraps.
  - IDLE: if pressedSync=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT:
    - pressedSync=0: go to IDLE, cnt=0 (bounce rejected, no pulse);
    - pressedSync=1 and cnt=DEBOUNCE_CYCLES-1: go to HELD and raise the raw event;
    - otherwise cnt++.
  - HELD: if pressedSync=0, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT:
    - pressedSync=1: go to HELD with no event (release bounce);
    - cnt=DEBOUNCE_CYCLES-1: go to IDLE;
    - otherwise cnt++.
- Level outputs: level = 1 in HELD and RELEASE_WAIT.
- Pulse generation: pulses are registered and high for exactly one cycle per raw event.
- Latency: if the raw key is low from before clock edge k and stays low, the pulse is high in the cycle after edge k+DEBOUNCE_CYCLES+1.
- Enable gating: with enable=0, pulses are forced to 0, while the FSMs and level outputs keep running. An event suppressed this way is lost and is not replayed when enable returns to 1.
- Simultaneous events: if inc and dec raw events occur in the same cycle, both pulses are suppressed for that cycle; both FSMs still enter HELD.
- Reset mid-operation: the FSM restarts in IDLE. A key held through reset deassertion is debounced afresh and produces one pulse.
- The block holds no other state and has no combinational path from input to output.

Optional Feature:
- Macro HOLD_REPEAT_EN.
- Defined: a repeat timer per button, cleared on every entry to HELD and whenever the FSM is not in HELD.
  - In HELD, the first extra raw event fires after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles while the key stays in HELD.
  - Repeat events obey the same enable gating and simultaneous-event rules as press events.
- Undefined: timers and the REPEAT_* parameters have no effect; exactly one pulse per accepted press.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset release, keys idle high for 50 cycles -> all outputs 0.
- incButRaw driven low before edge 10 and held -> incPulse high only in the cycle after edge 15, incLevel=1 from the same cycle; decPulse stays 0.
- decButRaw toggles low 2 cycles, high 1 cycle, repeated ×5, then held low -> no pulse during the bounce; exactly one decPulse after 4 stable synchronized low samples. Then a 2-cycle high glitch while held -> decLevel stays 1 and no second pulse.
- enable=0, full inc press and release -> incLevel follows the key (1, then 0 after 4 stable release samples), incPulse=0. Then enable=1 with no new press -> no pulse.
- Both raw keys driven low on the same edge -> no pulse on either output, incLevel=decLevel=1. Release both and press inc alone -> one incPulse.
- HOLD_REPEAT_EN defined, REPEAT_DELAY=20, REPEAT_PERIOD=8, inc held for 60 cycles after acceptance -> pulses at acceptance+1, +20, +28, +36, +44, +52 relative cycles. Reset asserted mid-hold -> all outputs 0 immediately.
